alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Drives the command side of the 4-bit-operand / 8-bit-accumulator ALU register block. It produces the Function/Data pair every cycle and reads back ALUout.
- Holds a small loadable program of (op, data) instructions and issues them one per clock on start.
- Captures the final accumulator value and reports completion with a one-cycle done pulse.
- Sits between the lab control logic (switches/keys) and the ALU.

Parameters:
DEPTH, 8, number of program slots (power of 2)
DATA_W, 4, operand width driven on Data
ACC_W, 8, accumulator width read from ALUout

Ports:
Clock  input  1  system clock; all state changes on posedge
Reset_b  input  1  synchronous active-low reset; shared with the ALU register
prog_we  input  1  program write strobe
prog_addr  input  log2(DEPTH)  program slot to write
prog_op  input  2  opcode to store
prog_data  input  DATA_W  operand to store
prog_len  input  log2(DEPTH)+1  number of instructions to run (0..DEPTH), sampled on start
start  input  1  begin execution; honoured only in IDLE
Function  output  2  ALU opcode
Data  output  DATA_W  ALU operand
ALUout  input  ACC_W  accumulator value from the ALU
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when result is valid
result  output  ACC_W  captured accumulator, held until the next capture

Behaviour:
- Reset is one clock and synchronous: Reset_b low at a posedge forces the following.
  - State goes to IDLE; pc, len_q and result are cleared to 0; busy and done go to 0.
  - Function = OP_HOLD (2'b11), Data = 0.
  - Program memory is NOT reset.
- Reset asserted mid-run aborts with no done pulse. Because the ALU shares Reset_b, the accumulator is also 0 afterwards.
- ALU contract: 00 add (Data + ALUout[3:0]), 01 mul (Data * ALUout[3:0]), 10 shift-left (ALUout << Data), 11 hold. The ALU register updates on the edge that ends the cycle in which the op is presented.
- Program write:
  - prog_we in IDLE or DONE writes {prog_op, prog_data} to mem[prog_addr] at the posedge.
  - prog_we during RUN or DRAIN is ignored.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Outputs Function = OP_HOLD, Data = 0.
  - start=1 with prog_len!=0: len_q <= prog_len, pc <= 0, go to RUN.
  - start=1 with prog_len==0: go directly to DRAIN.
- RUN:
  - Function/Data = mem[pc] (combinational from registered pc).
  - At each posedge pc increments. When pc == len_q-1, go to DRAIN.
  - Exactly len_q instructions are issued on consecutive cycles.
- DRAIN:
  - Function = OP_HOLD. ALUout now reflects all issued ops.
  - At the posedge: result <= ALUout, go to DONE.
- DONE:
  - done=1 for this single cycle.
  - Next state is IDLE. start in DONE is ignored.
- Timing: start sampled at edge 0 → RUN cycles 1..len → DRAIN cycle len+1 → done and new result visible in cycle len+2.
- busy=1 exactly in cycles 1..len+1.
- start while busy is ignored; no queuing.
- prog_len > DEPTH saturates to DEPTH.
- The accumulator is never cleared by this block between runs. A new run continues from the previous ALUout.
- Arithmetic is entirely inside the ALU. This block does no arithmetic beyond the pc increment, which never wraps because of the len_q bound.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_MUL=2'b01, OP_SHL=2'b10, OP_HOLD=2'b11;
  - a state enum typedef (IDLE, RUN, DRAIN, DONE);
  - a packed instr_t {op[1:0], data[DATA_W-1:0]}.
- One sub-module is natural: alu_prog_mem. It is DEPTH x instr_t with a synchronous write port and a combinational read port, and no reset.
- The FSM, pc and result capture stay in the top module.

Test Plan:
- Program {ADD 3, MUL 5, SHL 1}, prog_len=3, start → busy cycles 1..4; Function/Data = 00/3, 01/5, 10/1 in cycles 1..3; done in cycle 5; result=8'h1E.
- Immediately after that run, program slot0 = ADD 1, prog_len=1, start → result = 1 + 4'hE = 8'h0F (accumulator carried over, low nibble used).
- prog_len=0, start → busy only in cycle 1, done in cycle 2, result = current ALUout, Function stays 11 throughout.
- Pulse start during RUN, and prog_we to slot0 with ADD 7 during RUN → no restart, memory unchanged; a rerun shows the original slot0 op.
- Assert Reset_b=0 for one cycle in the middle of a 3-op run → next cycle IDLE, busy=0, done never pulses, result=0, Function=11, ALUout=0.
- Run with prog_len=8 using all slots set to ADD 1 → 8 consecutive issue cycles, done in cycle 10, result=8'h08.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, instruction word.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_seq_pkg;

  // ALU opcodes as understood by the accumulator register block.
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  localparam int INSTR_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [1:0]              op;
    logic [INSTR_DATA_W-1:0] data;
  } instr_t;

endpackage

// File: rtl/alu_prog_mem.sv
// Program store: DEPTH instruction slots, synchronous write, combinational read, no reset.
// Latency: write visible on read port the cycle after the write edge; read is zero-cycle.
// Backpressure: none; the caller gates the write enable.
//
// Ports: clk; we/waddr/wdat write port; raddr/rdat asynchronous read port.
module alu_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = instr_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  T              wdat,
  input  logic [AW-1:0] raddr,
  output T              rdat
);

  T mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues a loaded (op, data) program to the ALU one instruction per clock, then captures ALUout.
// Latency: start at edge 0 -> ops in cycles 1..len -> done/result in cycle len+2.
// Backpressure: none; start while busy and program writes while busy are dropped.
//
// Ports: Clock, Reset_b (sync, active low); prog_we/prog_addr/prog_op/prog_data load a slot;
//        prog_len/start launch a run; Function/Data drive the ALU, ALUout reads it back;
//        busy (RUN/DRAIN), done (one-cycle pulse), result (last captured accumulator).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter int  DATA_W = 4,
  parameter int  ACC_W  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              Clock,
  input  logic              Reset_b,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [1:0]        prog_op,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [LW-1:0]     prog_len,
  input  logic              start,
  output logic [1:0]        Function,
  output logic [DATA_W-1:0] Data,
  input  logic [ACC_W-1:0]  ALUout,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result
);

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] data;
  } seq_instr_t;

  seq_state_t      state_q, state_d;
  logic [AW-1:0]   pc_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   len_sat;
  logic            last_instr;
  logic            mem_we;
  seq_instr_t      wr_instr;
  seq_instr_t      rd_instr;

  // The program can only change while nothing is being issued.
  assign mem_we   = prog_we && (state_q == IDLE || state_q == DONE);
  assign wr_instr = '{op: prog_op, data: prog_data};

  alu_prog_mem #(
    .DEPTH (DEPTH),
    .T     (seq_instr_t)
  ) u_mem (
    .clk   (Clock),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdat  (wr_instr),
    .raddr (pc_q),
    .rdat  (rd_instr)
  );

  assign len_sat    = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  // len_q is never 0 while in RUN, so the subtraction cannot underflow there.
  assign last_instr = ({1'b0, pc_q} == (len_q - LW'(1)));

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start && prog_len != '0) begin
            len_q <= len_sat;
            pc_q  <= '0;
          end
        end
        RUN: begin
          // Hold pc on the final instruction so it never wraps past DEPTH-1.
          if (!last_instr) pc_q <= pc_q + AW'(1);
        end
        DRAIN: begin
          result <= ALUout;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    Function = OP_HOLD;
    Data     = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (prog_len != '0) ? RUN : DRAIN;
      end
      RUN: begin
        busy     = 1'b1;
        Function = rd_instr.op;
        Data     = rd_instr.data;
        if (last_instr) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural accumulator ALU closing the loop.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_op_sequencer;

  logic       clk;
  logic       Reset_b;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [1:0] prog_op;
  logic [3:0] prog_data;
  logic [3:0] prog_len;
  logic       start;
  logic [1:0] Function;
  logic [3:0] Data;
  logic [7:0] ALUout;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer dut (
    .Clock     (clk),
    .Reset_b   (Reset_b),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_op   (prog_op),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
    .Function  (Function),
    .Data      (Data),
    .ALUout    (ALUout),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accumulator ALU register sharing Reset_b with the sequencer.
  always @(posedge clk) begin
    if (!Reset_b) ALUout <= 8'h00;
    else begin
      case (Function)
        2'b00:   ALUout <= {4'h0, Data} + {4'h0, ALUout[3:0]};
        2'b01:   ALUout <= {4'h0, Data} * {4'h0, ALUout[3:0]};
        2'b10:   ALUout <= ALUout << Data;
        default: ALUout <= ALUout;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [2:0] a, input logic [1:0] op, input logic [3:0] d);
    prog_we = 1'b1; prog_addr = a; prog_op = op; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Raises start for the edge that becomes edge 0; returns positioned in cycle 1.
  task automatic launch(input logic [3:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    Reset_b = 1'b0;
    tick();
    tick();
    Reset_b = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", result); end
    n_checks++; if (Function !== 2'b11 || Data !== 4'h0) begin
      n_fail++; $display("FAIL reset_fd got %b/%h want 11/0", Function, Data); end
  endtask

  task automatic test_basic_program();
    logic [1:0] exp_f [3] = '{2'b00, 2'b01, 2'b10};
    logic [3:0] exp_d [3] = '{4'd3, 4'd5, 4'd1};
    write_slot(3'd0, 2'b00, 4'd3);
    write_slot(3'd1, 2'b01, 4'd5);
    write_slot(3'd2, 2'b10, 4'd1);
    launch(4'd3);
    for (int c = 1; c <= 6; c++) begin
      n_checks++; if (busy !== (c <= 4)) begin n_fail++; $display("FAIL basic_busy c%0d got %b", c, busy); end
      n_checks++; if (done !== (c == 5)) begin n_fail++; $display("FAIL basic_done c%0d got %b", c, done); end
      if (c <= 3) begin
        n_checks++; if (Function !== exp_f[c-1] || Data !== exp_d[c-1]) begin
          n_fail++; $display("FAIL basic_issue c%0d got %b/%h want %b/%h", c, Function, Data, exp_f[c-1], exp_d[c-1]); end
      end else begin
        n_checks++; if (Function !== 2'b11) begin n_fail++; $display("FAIL basic_hold c%0d got %b want 11", c, Function); end
      end
      if (c == 5) begin
        n_checks++; if (result !== 8'h1E) begin n_fail++; $display("FAIL basic_result got %h want 1e", result); end
      end
      tick();
    end
  endtask

  task automatic test_carry_over();
    write_slot(3'd0, 2'b00, 4'd1);
    launch(4'd1);
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (busy !== (c <= 2)) begin n_fail++; $display("FAIL carry_busy c%0d got %b", c, busy); end
      n_checks++; if (done !== (c == 3)) begin n_fail++; $display("FAIL carry_done c%0d got %b", c, done); end
      if (c == 3) begin
        n_checks++; if (result !== 8'h0F) begin n_fail++; $display("FAIL carry_result got %h want 0f", result); end
      end
      tick();
    end
  endtask

  task automatic test_zero_len();
    launch(4'd0);
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (busy !== (c == 1)) begin n_fail++; $display("FAIL zero_busy c%0d got %b", c, busy); end
      n_checks++; if (done !== (c == 2)) begin n_fail++; $display("FAIL zero_done c%0d got %b", c, done); end
      n_checks++; if (Function !== 2'b11) begin n_fail++; $display("FAIL zero_func c%0d got %b want 11", c, Function); end
      if (c == 2) begin
        n_checks++; if (result !== 8'h0F) begin n_fail++; $display("FAIL zero_result got %h want 0f", result); end
      end
      tick();
    end
  endtask

  // Program is ADD1, MUL5, SHL1; acc 0F -> 10 -> 00 -> 00.
  task automatic test_busy_ignores();
    launch(4'd3);
    start = 1'b1;
    prog_we = 1'b1; prog_addr = 3'd0; prog_op = 2'b00; prog_data = 4'd7;
    tick();
    start = 1'b0; prog_we = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      n_checks++; if (busy !== (c <= 4)) begin n_fail++; $display("FAIL ignore_busy c%0d got %b", c, busy); end
      n_checks++; if (done !== (c == 5)) begin n_fail++; $display("FAIL ignore_done c%0d got %b", c, done); end
      if (c == 2) begin
        n_checks++; if (Function !== 2'b01 || Data !== 4'd5) begin
          n_fail++; $display("FAIL ignore_issue2 got %b/%h want 01/5", Function, Data); end
      end
      if (c == 5) begin
        n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL ignore_result got %h want 00", result); end
      end
      tick();
    end
    launch(4'd1);
    n_checks++; if (Function !== 2'b00 || Data !== 4'd1) begin
      n_fail++; $display("FAIL ignore_slot0 got %b/%h want 00/1", Function, Data); end
    tick();
    tick();
    n_checks++; if (done !== 1'b1 || result !== 8'h01) begin
      n_fail++; $display("FAIL ignore_rerun got done=%b result=%h want 1/01", done, result); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    launch(4'd3);
    tick();
    Reset_b = 1'b0;
    tick();
    Reset_b = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL abort_result got %h want 00", result); end
    n_checks++; if (Function !== 2'b11) begin n_fail++; $display("FAIL abort_func got %b want 11", Function); end
    n_checks++; if (ALUout !== 8'h00) begin n_fail++; $display("FAIL abort_aluout got %h want 00", ALUout); end
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done step%0d got %b want 0", c, done); end
      tick();
    end
  endtask

  // All slots ADD 1: full depth from acc 0 gives 08; a saturated length 15 from 08 gives 10.
  task automatic test_full_depth();
    logic [3:0] lens [2] = '{4'd8, 4'd15};
    logic [7:0] exp_r [2] = '{8'h08, 8'h10};
    for (int s = 0; s < 8; s++) write_slot(3'(s), 2'b00, 4'd1);
    for (int r = 0; r < 2; r++) begin
      launch(lens[r]);
      for (int c = 1; c <= 11; c++) begin
        n_checks++; if (busy !== (c <= 9)) begin n_fail++; $display("FAIL full%0d_busy c%0d got %b", r, c, busy); end
        n_checks++; if (done !== (c == 10)) begin n_fail++; $display("FAIL full%0d_done c%0d got %b", r, c, done); end
        n_checks++; if (Function !== ((c <= 8) ? 2'b00 : 2'b11)) begin
          n_fail++; $display("FAIL full%0d_func c%0d got %b", r, c, Function); end
        if (c == 10) begin
          n_checks++; if (result !== exp_r[r]) begin
            n_fail++; $display("FAIL full%0d_result got %h want %h", r, result, exp_r[r]); end
        end
        tick();
      end
    end
  endtask

  initial begin
    Reset_b = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_data = '0;
    prog_len = '0; start = 1'b0;
    #1;
    test_reset();
    test_basic_program();
    test_carry_over();
    test_zero_len();
    test_busy_ignores();
    test_reset_mid_run();
    test_full_depth();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
